calc_n_top: RTL and testbench

//  Parametrised N-port tagged calculator; successor to the fixed 4-port calc2 core.

---
 rtl/calc_n_top_if.sv | 38 +++
 rtl/calc_n_top.sv | 220 ++++++++++++++++++++++
 tb/tb_calc_n_top.sv | 337 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/calc_n_top_if.sv
// ---------------------------------------------------------------------------
// calc_n_top_if
//   Request/response bundle for the N-port tagged calculator.
//   All vectors are flat, port p occupying slice [p*W +: W].
//
//   req_cmd_in   NUM_PORTS*4       command per port (0 = no-op)
//   req_data_in  NUM_PORTS*DATA_W  op1 in the cmd cycle, op2 in the next cycle
//   req_tag_in   NUM_PORTS*TAG_W   request tag, sampled in the cmd cycle
//   out_resp     NUM_PORTS*2       00 none, 01 ok, 10 error, 11 dropped
//   out_data     NUM_PORTS*DATA_W  result, zero unless resp == 01
//   out_tag      NUM_PORTS*TAG_W   tag of the responding request
//   port_full    NUM_PORTS         port queue full
//
//   master: request issuer, slave: calculator.
// ---------------------------------------------------------------------------
interface calc_n_top_if #(
   parameter int NUM_PORTS = 4,
   parameter int DATA_W    = 32,
   parameter int TAG_W     = 2
);
   logic [NUM_PORTS*4-1:0]      req_cmd_in;
   logic [NUM_PORTS*DATA_W-1:0] req_data_in;
   logic [NUM_PORTS*TAG_W-1:0]  req_tag_in;
   logic [NUM_PORTS*2-1:0]      out_resp;
   logic [NUM_PORTS*DATA_W-1:0] out_data;
   logic [NUM_PORTS*TAG_W-1:0]  out_tag;
   logic [NUM_PORTS-1:0]        port_full;

   modport master (
      output req_cmd_in, req_data_in, req_tag_in,
      input  out_resp, out_data, out_tag, port_full
   );

   modport slave (
      input  req_cmd_in, req_data_in, req_tag_in,
      output out_resp, out_data, out_tag, port_full
   );
endinterface

// File: rtl/calc_n_top.sv
// ---------------------------------------------------------------------------
// calc_n_top
//   N-port tagged calculator. Each port issues two-cycle requests (cmd+op1,
//   then op2) that are queued in a per-port FIFO. A round-robin arbiter picks
//   one FIFO head per cycle for a shared single-cycle ALU; the result is
//   registered onto the originating port together with its tag. A request
//   that finds its queue full is answered with a one-cycle drop response.
//
//   Ports:
//     c_clk   clock, rising edge
//     reset   synchronous, active-high
//     bus     calc_n_top_if.slave (request inputs, response outputs,
//             combinational per-port queue-full flags)
// ---------------------------------------------------------------------------
module calc_n_top #(
   parameter int NUM_PORTS  = 4,
   parameter int DATA_W     = 32,
   parameter int TAG_W      = 2,
   parameter int FIFO_DEPTH = 4
) (
   input  logic        c_clk,
   input  logic        reset,
   calc_n_top_if.slave bus
);
   localparam int PP_W  = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam int SH_W  = (DATA_W > 1) ? $clog2(DATA_W) : 1;

   localparam logic [3:0] CMD_ADD = 4'd1;
   localparam logic [3:0] CMD_SUB = 4'd2;
   localparam logic [3:0] CMD_SHL = 4'd5;
   localparam logic [3:0] CMD_SHR = 4'd6;

   localparam logic [1:0] RESP_NONE = 2'b00;
   localparam logic [1:0] RESP_OK   = 2'b01;
   localparam logic [1:0] RESP_ERR  = 2'b10;
   localparam logic [1:0] RESP_DROP = 2'b11;

   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);

   typedef enum logic {IDLE, GET_OP2} cap_state_t;

   // capture stage
   cap_state_t           cap_state  [NUM_PORTS];
   logic [3:0]           cap_cmd_p0 [NUM_PORTS];
   logic [DATA_W-1:0]    cap_op1_p0 [NUM_PORTS];
   logic [TAG_W-1:0]     cap_tag_p0 [NUM_PORTS];
   logic [NUM_PORTS-1:0] drop_pend;
   logic [TAG_W-1:0]     drop_tag   [NUM_PORTS];

   // queue stage
   logic [3:0]           fifo_cmd [NUM_PORTS][FIFO_DEPTH];
   logic [DATA_W-1:0]    fifo_op1 [NUM_PORTS][FIFO_DEPTH];
   logic [DATA_W-1:0]    fifo_op2 [NUM_PORTS][FIFO_DEPTH];
   logic [TAG_W-1:0]     fifo_tag [NUM_PORTS][FIFO_DEPTH];
   logic [PTR_W-1:0]     wr_ptr   [NUM_PORTS];
   logic [PTR_W-1:0]     rd_ptr   [NUM_PORTS];
   logic [CNT_W-1:0]     count    [NUM_PORTS];

   logic [NUM_PORTS-1:0] full;
   logic [NUM_PORTS-1:0] enq;
   logic [NUM_PORTS-1:0] deq;
   logic [NUM_PORTS-1:0] cmd_seen;

   logic [PP_W-1:0]      rr_ptr;
   logic [PP_W-1:0]      cand;
   logic                 gnt_vld;
   logic [PP_W-1:0]      gnt_port;

   logic [3:0]           head_cmd;
   logic [DATA_W-1:0]    head_op1;
   logic [DATA_W-1:0]    head_op2;
   logic [TAG_W-1:0]     head_tag;
   logic [DATA_W+1:0]    alu_res;

   // output stage
   logic [NUM_PORTS*2-1:0]      resp_p2;
   logic [NUM_PORTS*DATA_W-1:0] data_p2;
   logic [NUM_PORTS*TAG_W-1:0]  tag_p2;

   function automatic logic [PP_W-1:0] rr_step(input logic [PP_W-1:0] base, input int step);
      int s;
      s = int'(base) + step;
      if (s >= NUM_PORTS) s = s - NUM_PORTS;
      return PP_W'(s);
   endfunction

   // Returns {resp, data}; data is forced to zero on any error.
   function automatic logic [DATA_W+1:0] alu_eval(input logic [3:0]        cmd,
                                                  input logic [DATA_W-1:0] a,
                                                  input logic [DATA_W-1:0] b);
      logic [DATA_W:0]  sum;
      logic [SH_W-1:0]  sh;
      logic [DATA_W+1:0] res;
      sum = {1'b0, a} + {1'b0, b};
      sh  = b[SH_W-1:0];
      res = {RESP_ERR, {DATA_W{1'b0}}};
      case (cmd)
         CMD_ADD: if (!sum[DATA_W]) res = {RESP_OK, sum[DATA_W-1:0]};
         CMD_SUB: if (b <= a)       res = {RESP_OK, a - b};
         CMD_SHL: res = {RESP_OK, a << sh};
         CMD_SHR: res = {RESP_OK, a >> sh};
         default: res = {RESP_ERR, {DATA_W{1'b0}}};
      endcase
      return res;
   endfunction

   // Full is judged before this cycle's dequeue, so a request completing
   // capture on a full queue is dropped even if the head leaves this cycle.
   always_comb begin
      full     = '0;
      enq      = '0;
      deq      = '0;
      cmd_seen = '0;
      for (int p = 0; p < NUM_PORTS; p++) begin
         full[p]     = (count[p] == CNT_FULL);
         cmd_seen[p] = (cap_state[p] == IDLE) && (bus.req_cmd_in[4*p +: 4] != 4'd0);
         enq[p]      = (cap_state[p] == GET_OP2) && !full[p];
         deq[p]      = gnt_vld && (gnt_port == PP_W'(p));
      end
   end

   // A port with a pending drop response is skipped so its output slot is free.
   always_comb begin
      gnt_vld  = 1'b0;
      gnt_port = '0;
      cand     = '0;
      for (int i = 0; i < NUM_PORTS; i++) begin
         cand = rr_step(rr_ptr, i);
         if (!gnt_vld && (count[cand] != '0) && !drop_pend[cand]) begin
            gnt_vld  = 1'b1;
            gnt_port = cand;
         end
      end
   end

   always_comb begin
      head_cmd = fifo_cmd[gnt_port][rd_ptr[gnt_port]];
      head_op1 = fifo_op1[gnt_port][rd_ptr[gnt_port]];
      head_op2 = fifo_op2[gnt_port][rd_ptr[gnt_port]];
      head_tag = fifo_tag[gnt_port][rd_ptr[gnt_port]];
      alu_res  = alu_eval(head_cmd, head_op1, head_op2);
   end

   // control: capture FSMs, queue pointers, arbiter pointer, response registers
   always_ff @(posedge c_clk) begin
      if (reset) begin
         for (int p = 0; p < NUM_PORTS; p++) begin
            cap_state[p] <= IDLE;
            wr_ptr[p]    <= '0;
            rd_ptr[p]    <= '0;
            count[p]     <= '0;
         end
         drop_pend <= '0;
         rr_ptr    <= '0;
         resp_p2   <= '0;
         data_p2   <= '0;
         tag_p2    <= '0;
      end else begin
         for (int p = 0; p < NUM_PORTS; p++) begin
            resp_p2[2*p +: 2]           <= RESP_NONE;
            data_p2[DATA_W*p +: DATA_W] <= '0;
            tag_p2[TAG_W*p +: TAG_W]    <= '0;

            if (drop_pend[p]) begin
               resp_p2[2*p +: 2]        <= RESP_DROP;
               tag_p2[TAG_W*p +: TAG_W] <= drop_tag[p];
               drop_pend[p]             <= 1'b0;
            end

            if (deq[p]) begin
               resp_p2[2*p +: 2]           <= alu_res[DATA_W +: 2];
               data_p2[DATA_W*p +: DATA_W] <= alu_res[DATA_W-1:0];
               tag_p2[TAG_W*p +: TAG_W]    <= head_tag;
               rd_ptr[p]                   <= rd_ptr[p] + 1'b1;
            end

            case (cap_state[p])
               IDLE: begin
                  if (cmd_seen[p]) cap_state[p] <= GET_OP2;
               end
               GET_OP2: begin
                  cap_state[p] <= IDLE;
                  if (full[p]) drop_pend[p] <= 1'b1;
                  else         wr_ptr[p]    <= wr_ptr[p] + 1'b1;
               end
               default: cap_state[p] <= IDLE;
            endcase

            count[p] <= count[p] + CNT_W'(enq[p]) - CNT_W'(deq[p]);
         end
         if (gnt_vld) rr_ptr <= rr_step(gnt_port, 1);
      end
   end

   // data: operand capture and queue storage, qualified by control only
   always_ff @(posedge c_clk) begin
      for (int p = 0; p < NUM_PORTS; p++) begin
         if (cmd_seen[p]) begin
            cap_cmd_p0[p] <= bus.req_cmd_in[4*p +: 4];
            cap_op1_p0[p] <= bus.req_data_in[DATA_W*p +: DATA_W];
            cap_tag_p0[p] <= bus.req_tag_in[TAG_W*p +: TAG_W];
         end
         if (enq[p]) begin
            fifo_cmd[p][wr_ptr[p]] <= cap_cmd_p0[p];
            fifo_op1[p][wr_ptr[p]] <= cap_op1_p0[p];
            fifo_op2[p][wr_ptr[p]] <= bus.req_data_in[DATA_W*p +: DATA_W];
            fifo_tag[p][wr_ptr[p]] <= cap_tag_p0[p];
         end
         if ((cap_state[p] == GET_OP2) && full[p]) drop_tag[p] <= cap_tag_p0[p];
      end
   end

   assign bus.out_resp  = resp_p2;
   assign bus.out_data  = data_p2;
   assign bus.out_tag   = tag_p2;
   assign bus.port_full = full;

endmodule

// File: tb/tb_calc_n_top.sv
// ---------------------------------------------------------------------------
// tb_calc_n_top
//   Bench for calc_n_top (4 ports, 32-bit data, 2-bit tags, depth-4 queues).
//   A queue-based reference model predicts every port's outputs each cycle;
//   directed sequences add fixed expected values for the key scenarios,
//   followed by a randomized phase with occasional resets.
// ---------------------------------------------------------------------------
module tb_calc_n_top;
   localparam int NP    = 4;
   localparam int DW    = 32;
   localparam int TW    = 2;
   localparam int DEPTH = 4;

   typedef struct packed {
      logic [3:0]    cmd;
      logic [DW-1:0] a;
      logic [DW-1:0] b;
      logic [TW-1:0] tag;
   } req_t;

   logic clk   = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   calc_n_top_if #(.NUM_PORTS(NP), .DATA_W(DW), .TAG_W(TW)) bus ();

   calc_n_top #(
      .NUM_PORTS (NP),
      .DATA_W    (DW),
      .TAG_W     (TW),
      .FIFO_DEPTH(DEPTH)
   ) dut (
      .c_clk(clk),
      .reset(reset),
      .bus  (bus)
   );

   int n_tests = 0;
   int n_fail  = 0;

   // reference model
   req_t          mq      [NP][$];
   bit            m_busy  [NP];
   req_t          m_cap   [NP];
   bit            m_dpend [NP];
   logic [TW-1:0] m_dtag  [NP];
   int            m_rr;
   logic [1:0]    e_resp  [NP];
   logic [DW-1:0] e_data  [NP];
   logic [TW-1:0] e_tag   [NP];

   bit in_op2 [NP];

   task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: observed 0x%0h, expected 0x%0h", name, obs, exp);
      end
   endtask

   function automatic void ref_alu(input req_t r, output logic [1:0] resp, output logic [DW-1:0] data);
      longint unsigned a, b, s;
      int sh;
      a    = 64'(r.a);
      b    = 64'(r.b);
      sh   = int'(b % DW);
      resp = 2'b10;
      data = '0;
      case (r.cmd)
         4'd1: begin
            s = a + b;
            if (s < (64'd1 << DW)) begin resp = 2'b01; data = DW'(s); end
         end
         4'd2: if (b <= a) begin resp = 2'b01; data = DW'(a - b); end
         4'd5: begin resp = 2'b01; data = DW'(a << sh); end
         4'd6: begin resp = 2'b01; data = DW'(a >> sh); end
         default: ;
      endcase
   endfunction

   function automatic void model_step();
      int   sz [NP];
      int   g;
      int   idx;
      req_t r;
      logic [3:0] c;
      if (reset) begin
         for (int p = 0; p < NP; p++) begin
            mq[p].delete();
            m_busy[p]  = 1'b0;
            m_dpend[p] = 1'b0;
            e_resp[p]  = '0;
            e_data[p]  = '0;
            e_tag[p]   = '0;
         end
         m_rr = 0;
         return;
      end
      for (int p = 0; p < NP; p++) sz[p] = mq[p].size();
      g = -1;
      for (int i = 0; i < NP; i++) begin
         idx = (m_rr + i) % NP;
         if (g < 0 && sz[idx] > 0 && !m_dpend[idx]) g = idx;
      end
      for (int p = 0; p < NP; p++) begin
         e_resp[p] = '0;
         e_data[p] = '0;
         e_tag[p]  = '0;
         if (m_dpend[p]) begin
            e_resp[p]  = 2'b11;
            e_tag[p]   = m_dtag[p];
            m_dpend[p] = 1'b0;
         end
      end
      if (g >= 0) begin
         r = mq[g].pop_front();
         ref_alu(r, e_resp[g], e_data[g]);
         e_tag[g] = r.tag;
         m_rr     = (g + 1) % NP;
      end
      for (int p = 0; p < NP; p++) begin
         c = bus.req_cmd_in[4*p +: 4];
         if (m_busy[p]) begin
            m_cap[p].b = bus.req_data_in[DW*p +: DW];
            if (sz[p] == DEPTH) begin
               m_dpend[p] = 1'b1;
               m_dtag[p]  = m_cap[p].tag;
            end else begin
               mq[p].push_back(m_cap[p]);
            end
            m_busy[p] = 1'b0;
         end else if (c != 4'd0) begin
            m_busy[p]    = 1'b1;
            m_cap[p].cmd = c;
            m_cap[p].a   = bus.req_data_in[DW*p +: DW];
            m_cap[p].b   = '0;
            m_cap[p].tag = bus.req_tag_in[TW*p +: TW];
         end
      end
   endfunction

   task automatic compare_all();
      for (int p = 0; p < NP; p++) begin
         chk($sformatf("p%0d_resp", p), 64'(bus.out_resp[2*p +: 2]),  64'(e_resp[p]));
         chk($sformatf("p%0d_data", p), 64'(bus.out_data[DW*p +: DW]), 64'(e_data[p]));
         chk($sformatf("p%0d_tag", p),  64'(bus.out_tag[TW*p +: TW]),  64'(e_tag[p]));
         chk($sformatf("p%0d_full", p), 64'(bus.port_full[p]),        64'(mq[p].size() == DEPTH));
      end
   endtask

   task automatic run_cycle();
      @(posedge clk);
      model_step();
      @(negedge clk);
      compare_all();
   endtask

   task automatic set_port(input int p, input logic [3:0] cmd, input logic [DW-1:0] data,
                           input logic [TW-1:0] tag);
      bus.req_cmd_in[4*p +: 4]    = cmd;
      bus.req_data_in[DW*p +: DW] = data;
      bus.req_tag_in[TW*p +: TW]  = tag;
   endtask

   task automatic clear_inputs();
      bus.req_cmd_in  = '0;
      bus.req_data_in = '0;
      bus.req_tag_in  = '0;
   endtask

   task automatic issue(input int p, input logic [3:0] cmd, input logic [DW-1:0] op1,
                        input logic [DW-1:0] op2, input logic [TW-1:0] tag);
      clear_inputs();
      set_port(p, cmd, op1, tag);
      run_cycle();
      clear_inputs();
      set_port(p, 4'd0, op2, '0);
      run_cycle();
      clear_inputs();
   endtask

   function automatic logic [DW-1:0] pick_operand();
      case ($urandom_range(0, 5))
         0:       return '0;
         1:       return {DW{1'b1}};
         2:       return {1'b1, {(DW-1){1'b0}}};
         3:       return DW'($urandom_range(0, 40));
         default: return DW'($urandom);
      endcase
   endfunction

   function automatic logic [3:0] pick_cmd();
      case ($urandom_range(0, 9))
         0, 1, 2: return 4'd1;
         3, 4:    return 4'd2;
         5, 6:    return 4'd5;
         7, 8:    return 4'd6;
         default: return 4'($urandom_range(1, 15));
      endcase
   endfunction

   task automatic drive_rand(input int busy_pct);
      for (int p = 0; p < NP; p++) begin
         if (in_op2[p]) begin
            set_port(p, 4'($urandom_range(0, 15)), pick_operand(), TW'($urandom));
            in_op2[p] = 1'b0;
         end else if ($urandom_range(0, 99) < busy_pct) begin
            set_port(p, pick_cmd(), pick_operand(), TW'($urandom));
            in_op2[p] = 1'b1;
         end else begin
            set_port(p, 4'd0, DW'($urandom), TW'($urandom));
         end
      end
   endtask

   int ord [4];
   int seen_drop;
   int seen_full;
   int stale;

   initial begin
      clear_inputs();
      reset = 1'b1;
      run_cycle();
      run_cycle();
      chk("rst_resp", 64'(bus.out_resp),  64'd0);
      chk("rst_data", 64'(bus.out_data[63:0]), 64'd0);
      chk("rst_tag",  64'(bus.out_tag),   64'd0);
      chk("rst_full", 64'(bus.port_full), 64'd0);
      reset = 1'b0;
      run_cycle();

      // add 5+7 on port 0, response exactly three cycles after the cmd
      issue(0, 4'd1, 32'd5, 32'd7, 2'd1);
      run_cycle();
      chk("t1_resp", 64'(bus.out_resp[1:0]),  64'd1);
      chk("t1_data", 64'(bus.out_data[31:0]), 64'd12);
      chk("t1_tag",  64'(bus.out_tag[1:0]),   64'd1);
      run_cycle();
      chk("t1_hold", 64'(bus.out_resp[1:0]),  64'd0);

      // port 2 boundaries
      issue(2, 4'd1, 32'hFFFF_FFFF, 32'd1, 2'd2);
      run_cycle();
      chk("t2_carry_resp", 64'(bus.out_resp[5:4]),   64'd2);
      chk("t2_carry_data", 64'(bus.out_data[95:64]), 64'd0);
      issue(2, 4'd2, 32'd3, 32'd4, 2'd3);
      run_cycle();
      chk("t2_unf_resp", 64'(bus.out_resp[5:4]), 64'd2);
      issue(2, 4'd6, 32'h80, 32'h23, 2'd0);
      run_cycle();
      chk("t2_shr_resp", 64'(bus.out_resp[5:4]),   64'd1);
      chk("t2_shr_data", 64'(bus.out_data[95:64]), 64'h10);

      // invalid command on port 3
      issue(3, 4'd3, 32'd9, 32'd9, 2'd2);
      run_cycle();
      chk("t6_resp", 64'(bus.out_resp[7:6]),    64'd2);
      chk("t6_data", 64'(bus.out_data[127:96]), 64'd0);
      chk("t6_tag",  64'(bus.out_tag[7:6]),     64'd2);

      // all ports at once, pointer starts at 0
      ord = '{0, 1, 2, 3};
      for (int r = 0; r < 2; r++) begin
         if (r == 1) begin
            issue(1, 4'd1, 32'd10, 32'd20, 2'd0);
            run_cycle();
            ord = '{2, 3, 0, 1};
         end
         clear_inputs();
         for (int p = 0; p < NP; p++) set_port(p, 4'd1, DW'(p + 1), TW'(p));
         run_cycle();
         clear_inputs();
         for (int p = 0; p < NP; p++) set_port(p, 4'd0, 32'd100, '0);
         run_cycle();
         clear_inputs();
         for (int k = 0; k < 4; k++) begin
            run_cycle();
            chk($sformatf("t3_r%0d_order%0d", r, k), 64'(bus.out_resp[2*ord[k] +: 2]), 64'd1);
            chk($sformatf("t3_r%0d_data%0d", r, k), 64'(bus.out_data[DW*ord[k] +: DW]),
                64'(ord[k] + 101));
         end
      end

      // all ports back-to-back: queues fill, drops appear
      seen_drop = 0;
      seen_full = 0;
      for (int c = 0; c < 40; c++) begin
         for (int p = 0; p < NP; p++) begin
            if (c % 2 == 0) set_port(p, 4'd1, pick_operand(), TW'(c / 2));
            else            set_port(p, 4'($urandom_range(0, 15)), pick_operand(), '0);
         end
         run_cycle();
         if (bus.out_resp[3:2] == 2'b11) seen_drop++;
         if (bus.port_full[1]) seen_full++;
      end
      clear_inputs();
      chk("t4_drop_seen", 64'(seen_drop > 0), 64'd1);
      chk("t4_full_seen", 64'(seen_full > 0), 64'd1);

      // one-cycle reset with queued work
      reset = 1'b1;
      run_cycle();
      chk("t5_resp", 64'(bus.out_resp),  64'd0);
      chk("t5_tag",  64'(bus.out_tag),   64'd0);
      chk("t5_full", 64'(bus.port_full), 64'd0);
      reset = 1'b0;
      stale = 0;
      for (int c = 0; c < 6; c++) begin
         run_cycle();
         if (bus.out_resp != '0) stale++;
      end
      chk("t5_stale", 64'(stale), 64'd0);
      issue(0, 4'd1, 32'd2, 32'd3, 2'd3);
      run_cycle();
      chk("t5_new_resp", 64'(bus.out_resp[1:0]),  64'd1);
      chk("t5_new_data", 64'(bus.out_data[31:0]), 64'd5);
      chk("t5_new_tag",  64'(bus.out_tag[1:0]),   64'd3);

      // randomized traffic at varying load, rare resets
      for (int p = 0; p < NP; p++) in_op2[p] = 1'b0;
      for (int c = 0; c < 2400; c++) begin
         drive_rand((c < 800) ? 30 : ((c < 1600) ? 70 : 100));
         reset = ($urandom_range(0, 399) == 0);
         run_cycle();
         if (reset) for (int p = 0; p < NP; p++) in_op2[p] = 1'b0;
      end
      reset = 1'b0;
      clear_inputs();
      for (int c = 0; c < 30; c++) run_cycle();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
